logic_lamp_bank: RTL and testbench

//   Upstream stage of the multi-input gates: holds LAMP_COUNT logic-lamp states and drives them as the gate's

---
 rtl/wirelog_pkg.sv | 35 +++
 rtl/logic_lamp_bank_if.sv | 29 ++
 rtl/logic_lamp_bank_lamp_cell.sv | 35 +++
 rtl/logic_lamp_bank.sv | 93 +++++++++
 tb/tb_logic_lamp_bank.sv | 134 +++++++++++++
 5 files changed

// File: rtl/wirelog_pkg.sv
// ----------------------------------------------------------------------------
// wirelog_pkg
//   Shared helpers for the wire/lamp logic stages. The lamp bank uses them now,
//   and the output-pulse stage will use them later.
//   clog2   : ceiling log2, usable in localparam expressions
//   sat_add : adds an increment to a value and clamps the result at the
//             all-ones value of the given width (width <= 32)
// ----------------------------------------------------------------------------
package wirelog_pkg;

   function automatic int clog2(input int n);
      int result;
      result = 0;
      while ((1 << result) < n) begin
         result = result + 1;
      end
      return result;
   endfunction

   // The sum is formed one bit wider than either operand, so it cannot wrap
   // before it is compared against the limit.
   function automatic logic [31:0] sat_add(input logic [31:0] value,
                                           input logic [31:0] increment,
                                           input int          width);
      logic [32:0] sum;
      logic [32:0] limit;
      sum   = {1'b0, value} + {1'b0, increment};
      limit = (33'd1 << width) - 33'd1;
      if (sum > limit) begin
         return limit[31:0];
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/logic_lamp_bank_if.sv
// ----------------------------------------------------------------------------
// logic_lamp_bank_if
//   Groups the lamp bank's pulse inputs and its status outputs.
//   trig       : one-cycle wire pulses, bit [i*WIRE_COUNT+j] = wire j hits lamp i
//   hold       : freezes the lamp state and drops pulses that arrive meanwhile
//   lamp       : registered lamp states, which feed the gate input vector
//   changed    : one-cycle pulse when any lamp changed on this edge
//   stable     : no lamp change for at least SETTLE cycles
//   toggle_cnt : saturating count of lamp changes
//   master = pulse source / observer, slave = lamp bank
// ----------------------------------------------------------------------------
interface logic_lamp_bank_if #(
   parameter int LAMP_COUNT = 2,
   parameter int WIRE_COUNT = 2,
   parameter int CNT_WIDTH  = 8
);
   logic [LAMP_COUNT*WIRE_COUNT-1:0] trig;
   logic                             hold;
   logic [LAMP_COUNT-1:0]            lamp;
   logic                             changed;
   logic                             stable;
   logic [CNT_WIDTH-1:0]             toggle_cnt;

   modport master (output trig, hold,
                   input  lamp, changed, stable, toggle_cnt);

   modport slave  (input  trig, hold,
                   output lamp, changed, stable, toggle_cnt);
endinterface

// File: rtl/logic_lamp_bank_lamp_cell.sv
// ----------------------------------------------------------------------------
// lamp_cell
//   Holds one lamp. The lamp flips when an odd number of its wires pulse in the
//   same cycle and hold is low.
//   clk, logic_reset : clock, synchronous active-high reset (loads INIT)
//   hits             : this lamp's WIRE_COUNT pulse lines
//   hold             : gates off the flip
//   state            : registered lamp value
//   flip             : combinational, 1 when the lamp changes on the next edge
// ----------------------------------------------------------------------------
module lamp_cell #(
   parameter int   WIRE_COUNT = 2,
   parameter logic INIT       = 1'b0
) (
   input  logic                  clk,
   input  logic                  logic_reset,
   input  logic [WIRE_COUNT-1:0] hits,
   input  logic                  hold,
   output logic                  state,
   output logic                  flip
);

   // Parity of the hits: two hits cancel, and three hits act as a single flip.
   assign flip = (^hits) & ~hold;

   // Lamp flop. Reset takes priority over any pulse in the same cycle.
   always_ff @(posedge clk) begin
      if (logic_reset) begin
         state <= INIT;
      end else begin
         state <= state ^ flip;
      end
   end

endmodule

// File: rtl/logic_lamp_bank.sv
// ----------------------------------------------------------------------------
// logic_lamp_bank
//   Bank of LAMP_COUNT lamps that drives the parallel input of a multi-input
//   gate. It also reports when the lamps move (changed, toggle_cnt) and when
//   they have gone quiet (stable).
//   clk         : single clock, rising edge
//   logic_reset : synchronous active-high reset
//   bus         : logic_lamp_bank_if slave (trig/hold in; lamp, changed,
//                 stable and toggle_cnt out)
// ----------------------------------------------------------------------------
module logic_lamp_bank
   import wirelog_pkg::*;
#(
   parameter int                    LAMP_COUNT = 2,
   parameter int                    WIRE_COUNT = 2,
   parameter logic [LAMP_COUNT-1:0] INIT       = '0,
   parameter int                    SETTLE     = 4,
   parameter int                    CNT_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              logic_reset,
   logic_lamp_bank_if.slave  bus
);

   localparam int POP_W = clog2(LAMP_COUNT) + 1;
   localparam int Q_W   = clog2(SETTLE + 1);

   logic [LAMP_COUNT-1:0] lamp_state;
   logic [LAMP_COUNT-1:0] flip;
   logic [POP_W-1:0]      flip_count;
   logic [Q_W-1:0]        quiet_q;
   logic [Q_W-1:0]        quiet_next;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  changed_q;
   logic                  stable_q;

   // One cell per lamp. Each cell sees only its own slice of the wire vector.
   for (genvar i = 0; i < LAMP_COUNT; i++) begin : g_cell
      lamp_cell #(
         .WIRE_COUNT (WIRE_COUNT),
         .INIT       (INIT[i])
      ) u_cell (
         .clk         (clk),
         .logic_reset (logic_reset),
         .hits        (bus.trig[i*WIRE_COUNT +: WIRE_COUNT]),
         .hold        (bus.hold),
         .state       (lamp_state[i]),
         .flip        (flip[i])
      );
   end

   // Number of lamps that flip on this edge. When several lamps flip together,
   // each one adds to the toggle count.
   always_comb begin
      flip_count = '0;
      for (int i = 0; i < LAMP_COUNT; i++) begin
         flip_count = flip_count + POP_W'(flip[i]);
      end
   end

   // The quiet counter restarts on any flip and saturates at SETTLE. stable is
   // derived from the next value so that it lines up with the lamp update.
   always_comb begin
      quiet_next = quiet_q;
      if (|flip) begin
         quiet_next = '0;
      end else if (quiet_q != Q_W'(SETTLE)) begin
         quiet_next = quiet_q + 1'b1;
      end
   end

   // Status registers. hold only masks the flips, so these keep running and
   // held idle cycles still count toward stable.
   always_ff @(posedge clk) begin
      if (logic_reset) begin
         cnt_q     <= '0;
         changed_q <= 1'b0;
         stable_q  <= 1'b0;
         quiet_q   <= '0;
      end else begin
         cnt_q     <= CNT_WIDTH'(sat_add(32'(cnt_q), 32'(flip_count), CNT_WIDTH));
         changed_q <= |flip;
         stable_q  <= (quiet_next == Q_W'(SETTLE));
         quiet_q   <= quiet_next;
      end
   end

   assign bus.lamp       = lamp_state;
   assign bus.changed    = changed_q;
   assign bus.stable     = stable_q;
   assign bus.toggle_cnt = cnt_q;

endmodule

// File: tb/tb_logic_lamp_bank.sv
// ----------------------------------------------------------------------------
// tb_logic_lamp_bank
//   Directed bench for logic_lamp_bank. dutA uses the default 8-bit counter.
//   dutB is identical except for a 3-bit counter, which is used to exercise
//   saturation. Both DUTs receive the same stimulus.
// ----------------------------------------------------------------------------
module tb_logic_lamp_bank;

   logic clk;
   logic logic_reset;
   int   assert_count;
   int   fail_count;

   logic_lamp_bank_if #(.LAMP_COUNT(2), .WIRE_COUNT(2), .CNT_WIDTH(8)) bus_a ();
   logic_lamp_bank_if #(.LAMP_COUNT(2), .WIRE_COUNT(2), .CNT_WIDTH(3)) bus_b ();

   logic_lamp_bank #(
      .LAMP_COUNT (2),
      .WIRE_COUNT (2),
      .INIT       (2'b10),
      .SETTLE     (4),
      .CNT_WIDTH  (8)
   ) dut_a (
      .clk         (clk),
      .logic_reset (logic_reset),
      .bus         (bus_a.slave)
   );

   logic_lamp_bank #(
      .LAMP_COUNT (2),
      .WIRE_COUNT (2),
      .INIT       (2'b10),
      .SETTLE     (4),
      .CNT_WIDTH  (3)
   ) dut_b (
      .clk         (clk),
      .logic_reset (logic_reset),
      .bus         (bus_b.slave)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs, waits for the edge, and then settles 1 ns so
   // that the outputs are sampled away from the edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] trig, input logic hold);
      logic_reset = rst;
      bus_a.trig  = trig;
      bus_a.hold  = hold;
      bus_b.trig  = trig;
      bus_b.hold  = hold;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count = assert_count + 1;
      if (observed !== expected) begin
         fail_count = fail_count + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Checks the common outputs of dutA against expected values.
   task automatic checkA(input string tag, input logic [1:0] lamp, input logic changed,
                         input logic stable, input logic [7:0] cnt);
      checkOutput({tag, ".lamp"},    32'(bus_a.lamp),       32'(lamp));
      checkOutput({tag, ".changed"}, 32'(bus_a.changed),    32'(changed));
      checkOutput({tag, ".stable"},  32'(bus_a.stable),     32'(stable));
      checkOutput({tag, ".cnt"},     32'(bus_a.toggle_cnt), 32'(cnt));
   endtask

   initial begin
      assert_count = 0;
      fail_count   = 0;
      logic_reset  = 1'b1;
      bus_a.trig   = '0;
      bus_a.hold   = 1'b0;
      bus_b.trig   = '0;
      bus_b.hold   = 1'b0;

      // 1: reset, then idle. stable rises on the 4th edge after release.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      checkA("reset", 2'b10, 1'b0, 1'b0, 8'd0);
      checkOutput("reset.cnt_b", 32'(bus_b.toggle_cnt), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 4'b0000, 1'b0);
         checkA($sformatf("idle%0d", k), 2'b10, 1'b0, (k >= 4), 8'd0);
      end

      // 2: single hit on lamp0
      applyStimulus(1'b0, 4'b0001, 1'b0);
      checkA("hit0", 2'b11, 1'b1, 1'b0, 8'd1);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkA("hit0_after", 2'b11, 1'b0, 1'b0, 8'd1);

      // 3: a double hit cancels, then both lamps are hit once each
      applyStimulus(1'b0, 4'b0011, 1'b0);
      checkA("double", 2'b11, 1'b0, 1'b0, 8'd1);
      applyStimulus(1'b0, 4'b0101, 1'b0);
      checkA("both", 2'b00, 1'b1, 1'b0, 8'd3);
      checkOutput("both.cnt_b", 32'(bus_b.toggle_cnt), 32'd3);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkA("both_after", 2'b00, 1'b0, 1'b0, 8'd3);

      // 4: hold drops all pulses, and the quiet counter keeps running
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 4'b1111, 1'b1);
         checkA($sformatf("hold%0d", k), 2'b00, 1'b0, (k >= 3), 8'd3);
      end

      // 5: saturation on the 3-bit counter over 9 single toggles
      applyStimulus(1'b1, 4'b0000, 1'b0);
      checkOutput("rst2.cnt_b", 32'(bus_b.toggle_cnt), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(1'b0, 4'b0001, 1'b0);
         checkOutput($sformatf("sat%0d.cnt_b", k), 32'(bus_b.toggle_cnt), 32'((k > 7) ? 7 : k));
         checkOutput($sformatf("sat%0d.cnt_a", k), 32'(bus_a.toggle_cnt), 32'(k));
         checkOutput($sformatf("sat%0d.lamp", k),  32'(bus_a.lamp), 32'((k % 2 == 1) ? 2'b11 : 2'b10));
      end

      // 6: reset overrides a pulse in the same cycle
      applyStimulus(1'b1, 4'b0101, 1'b0);
      checkA("rst_pulse", 2'b10, 1'b0, 1'b0, 8'd0);
      checkOutput("rst_pulse.cnt_b", 32'(bus_b.toggle_cnt), 32'd0);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkA("rst_pulse_after", 2'b10, 1'b0, 1'b0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
